ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that turns Dual_Port_RAM into a streaming FIFO.
- Sits directly upstream and downstream of the RAM:
  - RAM port 1 is the write port.
  - RAM port 2 is the read port.
- Drives RAM address, data and write-enables, and consumes RAM Output_2.
- Exposes valid/ready push and pop interfaces with first-word-fall-through semantics via a 2-entry output buffer.

---
 rtl/ram_fifo_pkg.sv | 21 ++
 rtl/ram_fifo_outbuf.sv | 45 ++++
 rtl/ram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed FIFO controller and its output skid buffer.
package ram_fifo_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = 2;

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // One extra pointer bit distinguishes full from empty when the indices match.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Count spans RAM depth plus the buffer/in-flight words, so 0..DEPTH+2.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry first-word-fall-through buffer fed by the registered RAM read port.
module ram_fifo_outbuf
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fill,
  input  logic [DATA_W-1:0]    i_fill_data,
  input  logic                 i_pop,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output logic [BUF_CNT_W-1:0] o_cnt
);

  logic [DATA_W-1:0]    r_mem [BUF_DEPTH];
  logic                 r_head;
  logic [BUF_CNT_W-1:0] r_cnt;
  logic                 w_pop;
  logic                 w_wr_idx;

  assign w_pop    = i_pop & (r_cnt != '0);
  // Slot after the last valid entry; the upstream issue logic guarantees it is free.
  assign w_wr_idx = r_head ^ r_cnt[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + BUF_CNT_W'(i_fill) - BUF_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fill) r_mem[w_wr_idx] <= i_fill_data;
  end

  assign o_valid = (r_cnt != '0);
  assign o_data  = o_valid ? r_mem[r_head] : '0;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around an external dual-port RAM (port 1 write, port 2 read).
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic [IN_DATA_WIDTH-1:0] In_Data,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  output logic [IN_DATA_WIDTH-1:0] Out_Data,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [IN_DATA_WIDTH-1:0] RAM_Data_1,
  output logic [ADDR_WIDTH-1:0]    RAM_Address_1,
  output logic                     RAM_WE_1,
  output logic [IN_DATA_WIDTH-1:0] RAM_Data_2,
  output logic [ADDR_WIDTH-1:0]    RAM_Address_2,
  output logic                     RAM_WE_2,
  input  logic [IN_DATA_WIDTH-1:0] RAM_Output_2,
  output logic [ADDR_WIDTH+1:0]    Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int PTR_W = ptr_w(ADDR_WIDTH);
  localparam int CNT_W = cnt_w(ADDR_WIDTH);

  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic                 r_pend;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     w_ram_used;
  logic [BUF_CNT_W-1:0] w_buf_cnt;
  logic [BUF_CNT_W:0]   w_occ;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_out_valid;

  assign w_ram_used = r_wr_ptr - r_rd_ptr;
  assign In_Ready   = (w_ram_used != PTR_W'(DEPTH));
  // Reset is folded in so the RAM never sees a write strobe while RST_n is low.
  assign w_push     = In_Valid & In_Ready & RST_n;
  assign w_pop      = w_out_valid & Out_Ready;

  // Buffer slots committed after this edge: held words plus the in-flight read, minus a pop.
  assign w_occ   = {1'b0, w_buf_cnt} + (BUF_CNT_W+1)'(r_pend) - (BUF_CNT_W+1)'(w_pop);
  assign w_issue = (w_ram_used != '0) && (w_occ < (BUF_CNT_W+1)'(BUF_DEPTH));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pend   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_pend  <= w_issue;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  ram_fifo_outbuf #(
    .DATA_W (IN_DATA_WIDTH)
  ) u_outbuf (
    .i_clk       (CLK),
    .i_rst_n     (RST_n),
    .i_fill      (r_pend),
    .i_fill_data (RAM_Output_2),
    .i_pop       (w_pop),
    .o_data      (Out_Data),
    .o_valid     (w_out_valid),
    .o_cnt       (w_buf_cnt)
  );

  assign Out_Valid     = w_out_valid;
  assign RAM_WE_1      = w_push;
  assign RAM_Address_1 = r_wr_ptr[ADDR_WIDTH-1:0];
  assign RAM_Data_1    = In_Data;
  assign RAM_Data_2    = '0;
  assign RAM_WE_2      = 1'b0;
  assign RAM_Address_2 = r_rd_ptr[ADDR_WIDTH-1:0];
  assign Count         = r_count;
  assign Full          = ~In_Ready;
  assign Empty         = (r_count == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural dual-port RAM attached.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready = 1'b0;
  logic [DW-1:0] RAM_Data_1, RAM_Data_2, RAM_Output_2;
  logic [AW-1:0] RAM_Address_1, RAM_Address_2;
  logic          RAM_WE_1, RAM_WE_2;
  logic [AW+1:0] Count;
  logic          Full, Empty;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] ram_mem [DEPTH];

  ram_fifo_ctrl #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .In_Data       (In_Data),
    .In_Valid      (In_Valid),
    .In_Ready      (In_Ready),
    .Out_Data      (Out_Data),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .RAM_Data_1    (RAM_Data_1),
    .RAM_Address_1 (RAM_Address_1),
    .RAM_WE_1      (RAM_WE_1),
    .RAM_Data_2    (RAM_Data_2),
    .RAM_Address_2 (RAM_Address_2),
    .RAM_WE_2      (RAM_WE_2),
    .RAM_Output_2  (RAM_Output_2),
    .Count         (Count),
    .Full          (Full),
    .Empty         (Empty)
  );

  always #5 CLK = ~CLK;

  // Dual-port RAM with registered read output
  always @(posedge CLK) begin
    if (RAM_WE_1) ram_mem[RAM_Address_1] <= RAM_Data_1;
    if (RAM_WE_2) ram_mem[RAM_Address_2] <= RAM_Data_2;
    RAM_Output_2 <= ram_mem[RAM_Address_2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Monitor: handshakes are sampled mid-cycle, committed at the following rising edge.
  always @(negedge CLK) begin
    if (RST_n) begin
      check("count_vs_model", 32'(Count), 32'(model_q.size()));
      check("empty_vs_model", 32'(Empty), 32'(model_q.size() == 0));
      if (model_q.size() < DEPTH) check("full_low", 32'(Full), 32'd0);
      if (model_q.size() == DEPTH + 2) check("full_high", 32'(Full), 32'd1);
      if (Out_Valid && Out_Ready) begin
        if (model_q.size() == 0) fail_now("pop_underflow");
        else check("pop_data", 32'(Out_Data), 32'(model_q.pop_front()));
        pops++;
      end
      if (In_Valid && In_Ready) model_q.push_back(In_Data);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int c = 0;
    In_Valid = 1'b1;
    In_Data  = d;
    while (!In_Ready && c < 500) begin
      tick();
      c++;
    end
    if (!In_Ready) fail_now("push_timeout");
    tick();
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    Out_Ready = 1'b1;
    while (!Empty && c < 3000) begin
      tick();
      c++;
    end
    if (!Empty) fail_now("drain_timeout");
    Out_Ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    int max_cnt;
    int pushed;
    int cyc;

    // Reset then idle
    RST_n = 1'b0;
    tick(); tick();
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_data", 32'(Out_Data), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    In_Valid = 1'b1;
    #1;
    check("rst_we1_gated", 32'(RAM_WE_1), 32'd0);
    In_Valid = 1'b0;
    tick();
    RST_n = 1'b1;
    tick(); tick();
    check("idle_we1", 32'(RAM_WE_1), 32'd0);
    check("idle_we2", 32'(RAM_WE_2), 32'd0);
    check("idle_empty", 32'(Empty), 32'd1);

    // Single push of B5, latency two edges
    In_Valid = 1'b1;
    In_Data  = 8'hB5;
    #1;
    check("single_we1", 32'(RAM_WE_1), 32'd1);
    check("single_addr1", 32'(RAM_Address_1), 32'd0);
    check("single_data1", 32'(RAM_Data_1), 32'hB5);
    tick();
    In_Valid = 1'b0;
    tick();
    check("single_not_yet", 32'(Out_Valid), 32'd0);
    tick();
    check("single_valid", 32'(Out_Valid), 32'd1);
    check("single_data", 32'(Out_Data), 32'hB5);
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    check("single_empty", 32'(Empty), 32'd1);

    // Fill to capacity: 64 in RAM plus 2 in the buffer
    for (int i = 0; i < 66; i++) push_word(8'(i));
    tick();
    check("fill_count", 32'(Count), 32'd66);
    check("fill_full", 32'(Full), 32'd1);
    check("fill_in_ready", 32'(In_Ready), 32'd0);
    In_Valid = 1'b1;
    In_Data  = 8'hFF;
    #1;
    check("fill_we1_blocked", 32'(RAM_WE_1), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    In_Valid = 1'b0;
    check("fill_ignored", 32'(Count), 32'd66);
    pops = 0;
    drain();
    check("fill_drain_pops", 32'(pops), 32'd66);

    // Continuous streaming across pointer wrap
    bubbles = 0;
    max_cnt = 0;
    Out_Ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      In_Valid = 1'b1;
      In_Data  = 8'(i + 8'h40);
      tick();
      if (i >= 2 && !Out_Valid) bubbles++;
      if (int'(Count) > max_cnt) max_cnt = int'(Count);
    end
    In_Valid = 1'b0;
    check("stream_bubbles", 32'(bubbles), 32'd0);
    check("stream_max_count_le3", 32'(max_cnt <= 3), 32'd1);
    drain();

    // Random traffic with backpressure
    pushed = 0;
    cyc = 0;
    while (pushed < 1000 && cyc < 20000) begin
      In_Valid  = ($urandom_range(1, 0) == 1);
      In_Data   = 8'($urandom);
      Out_Ready = ($urandom_range(1, 0) == 1);
      #0;
      if (In_Valid && In_Ready) pushed++;
      tick();
      cyc++;
    end
    In_Valid = 1'b0;
    check("random_pushed", 32'(pushed), 32'd1000);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) push_word(8'(8'h10 + i));
    check("pre_rst_count", 32'(Count), 32'd10);
    #2;
    RST_n = 1'b0;
    #1;
    check("async_count", 32'(Count), 32'd0);
    check("async_empty", 32'(Empty), 32'd1);
    check("async_out_valid", 32'(Out_Valid), 32'd0);
    check("async_out_data", 32'(Out_Data), 32'd0);
    check("async_full", 32'(Full), 32'd0);
    model_q.delete();
    tick(); tick();
    RST_n = 1'b1;
    tick();
    pops = 0;
    push_word(8'hA3);
    drain();
    check("post_rst_pops", 32'(pops), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
